reg_bus_arbiter: RTL and testbench
==================================

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter NREG, default 8, meaning the number of reg_32 registers on the shared tristate bus; register index width is 3 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port clr, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have ports req0/req1, input, 1 bit each: transfer request from requester 0/1.
REQ-005 SHALL have ports src0/src1, input, 3 bits each: source register index for requester 0/1.
REQ-006 SHALL have ports dst0/dst1, input, 3 bits each: destination register index for requester 0/1.
REQ-007 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse to requester 0/1.
REQ-008 SHALL have port err, output, 1 bit: pulse coincident with ack when the transfer was suppressed.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port out_en, output, NREG bits: per-register out_enable (bus drive).
REQ-011 SHALL have port in_en, output, NREG bits: per-register in_enable (capture from bus).
REQ-012 SHALL have port xfer_cnt, output, 8 bits: count of completed non-suppressed transfers.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WRITE, ACK; all outputs registered or decoded from registered state only.
REQ-014 SHALL, in IDLE with any req high at a clock edge, latch the winner's index, src and dst and enter DRIVE; otherwise remain in IDLE.
REQ-015 SHALL arbitrate round-robin: priority pointer starts at requester 0; after granting requester k, it favours the other requester; a lone request always wins.
REQ-016 SHALL, in DRIVE, assert out_en[src] only (bus turnaround cycle), then enter WRITE.
REQ-017 SHALL, in WRITE, assert out_en[src] and in_en[dst] together for exactly one cycle, then enter ACK.
REQ-018 SHALL, in ACK, assert ack of the granted requester for one cycle with all enables low, then return to IDLE.
REQ-019 SHALL mark a transfer suppressed if dst==0 (write-protected) or src==dst; a suppressed transfer keeps out_en and in_en all low in DRIVE and WRITE, pulses err with ack, and does not increment xfer_cnt.
REQ-020 SHALL keep out_en and in_en each at most one-hot, and SHALL never assert in_en in a cycle without out_en.
REQ-021 SHALL sample src/dst only at grant; later changes are ignored for the transfer in flight.
REQ-022 SHALL treat a req still high in the cycle after ack as a new request, eligible in the next IDLE.
REQ-023 SHALL increment xfer_cnt by 1 in ACK for non-suppressed transfers, wrapping 255 -> 0.
REQ-024 SHALL give latency: req high at edge t -> DRIVE cycle t+1, WRITE t+2, ack high t+3, next grant no earlier than edge t+4.
REQ-025 SHALL ignore requests arriving while busy; the pending requester keeps req high until served.

Reset
REQ-026 SHALL, when clr is low at a clock edge, enter IDLE and clear out_en, in_en, ack0, ack1, err, busy, xfer_cnt to 0 and set the priority pointer to requester 0.
REQ-027 SHALL abort any transfer in flight on reset with no ack issued; no in_en asserted in the cycle following the reset edge.

Verification
REQ-028 Single transfer: req0=1, src0=3, dst0=5 -> out_en=0x08 for one cycle, then out_en=0x08 and in_en=0x20 for one cycle, then ack0=1, xfer_cnt=1.
REQ-029 Contention: req0 and req1 both high from reset -> requester 0 served first, then requester 1; repeat with both held -> grants alternate 0,1,0,1.
REQ-030 Suppression: req1=1, src1=2, dst1=0 -> out_en=in_en=0 throughout, ack1=1 with err=1, xfer_cnt unchanged; same for src1=dst1=4.
REQ-031 Reset mid-operation: clr low during WRITE -> next cycle IDLE, all enables 0, no ack, xfer_cnt=0.
REQ-032 Wrap: 256 non-suppressed transfers -> xfer_cnt returns to 0; one-hot/no-in_en-without-out_en assertions hold every cycle.
REQ-033 Late operand change: src0 changed from 3 to 6 during DRIVE -> out_en remains 0x08 through WRITE.

Source files
------------

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter that sequences register-to-register transfers on a shared tristate bus.
module reg_bus_arbiter #(
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req0,
  input  logic            req1,
  input  logic [2:0]      src0,
  input  logic [2:0]      src1,
  input  logic [2:0]      dst0,
  input  logic [2:0]      dst1,
  output logic            ack0,
  output logic            ack1,
  output logic            err,
  output logic            busy,
  output logic [NREG-1:0] out_en,
  output logic [NREG-1:0] in_en,
  output logic [7:0]      xfer_cnt
);
  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, ACK} state_t;
  state_t state_q;
  logic gnt_q, ptr_q, sup_q, ack0_q, ack1_q, err_q;
  logic gnt_d, sup_d;
  logic [2:0] src_q, dst_q, src_d, dst_d;
  logic [NREG-1:0] out_en_q, in_en_q;
  logic [7:0] xfer_cnt_q;
  always_comb begin
    gnt_d = (req0 && req1) ? ptr_q : req1;
    src_d = gnt_d ? src1 : src0;
    dst_d = gnt_d ? dst1 : dst0;
    sup_d = (dst_d == 3'd0) || (src_d == dst_d);
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'b0;
      sup_q      <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      out_en_q   <= '0;
      in_en_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req0 || req1) begin
          state_q  <= DRIVE;
          gnt_q    <= gnt_d;
          ptr_q    <= !gnt_d;
          src_q    <= src_d;
          dst_q    <= dst_d;
          sup_q    <= sup_d;
          out_en_q <= sup_d ? '0 : NREG'(1) << src_d;
        end
        DRIVE: begin
          state_q <= WRITE;
          in_en_q <= sup_q ? '0 : NREG'(1) << dst_q;
        end
        WRITE: begin
          state_q    <= ACK;
          out_en_q   <= '0;
          in_en_q    <= '0;
          ack0_q     <= !gnt_q;
          ack1_q     <= gnt_q;
          err_q      <= sup_q;
          xfer_cnt_q <= sup_q ? xfer_cnt_q : xfer_cnt_q + 8'd1;
        end
        default: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end
  assign busy     = state_q != IDLE;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err      = err_q;
  assign out_en   = out_en_q;
  assign in_en    = in_en_q;
  assign xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed checks of grant order, enable sequencing, suppression, reset abort and counter wrap.
module tb_reg_bus_arbiter;
  logic clk = 1'b0, clr = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic [2:0] src0 = '0, src1 = '0, dst0 = '0, dst1 = '0;
  logic ack0, ack1, err, busy;
  logic [7:0] out_en, in_en, xfer_cnt;
  int n_cmp = 0, n_err = 0;
  logic mon = 1'b0;
  reg_bus_arbiter #(.NREG(8)) dut (
    .clk(clk), .clr(clr), .req0(req0), .req1(req1),
    .src0(src0), .src1(src1), .dst0(dst0), .dst1(dst1),
    .ack0(ack0), .ack1(ack1), .err(err), .busy(busy),
    .out_en(out_en), .in_en(in_en), .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    clr = 1'b0;
    tick();
    clr = 1'b1;
  endtask
  task automatic do_xfer(input logic g, input logic [7:0] oe, input logic [7:0] ie, input logic e, input logic [7:0] cnt);
    tick();
    chk("drv_busy", busy, 1);
    chk("drv_oe", out_en, oe);
    chk("drv_ie", in_en, 0);
    tick();
    chk("wr_oe", out_en, oe);
    chk("wr_ie", in_en, ie);
    tick();
    chk("ack0", ack0, !g);
    chk("ack1", ack1, g);
    chk("ack_err", err, e);
    chk("ack_oe", out_en, 0);
    chk("ack_ie", in_en, 0);
    chk("ack_cnt", xfer_cnt, cnt);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ack", {ack0, ack1, err}, 0);
  endtask
  always @(negedge clk) if (mon) begin
    chk("oe_onehot", $onehot0(out_en), 1);
    chk("ie_onehot", $onehot0(in_en), 1);
    chk("ie_wo_oe", (in_en != 0) && (out_en == 0), 0);
    chk("two_acks", ack0 && ack1, 0);
  end
  initial begin
    tick();
    tick();
    mon = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_oe", out_en, 0);
    chk("rst_ie", in_en, 0);
    chk("rst_ack", {ack0, ack1, err}, 0);
    chk("rst_cnt", xfer_cnt, 0);
    clr = 1'b1;
    req0 = 1'b1; src0 = 3'd3; dst0 = 3'd5;
    tick();
    chk("t1_drv_oe", out_en, 8'h08);
    chk("t1_drv_ie", in_en, 8'h00);
    src0 = 3'd6;
    req0 = 1'b0;
    tick();
    chk("t1_wr_oe", out_en, 8'h08);
    chk("t1_wr_ie", in_en, 8'h20);
    tick();
    chk("t1_ack0", ack0, 1);
    chk("t1_err", err, 0);
    chk("t1_cnt", xfer_cnt, 1);
    tick();
    chk("t1_idle", busy, 0);
    do_reset();
    req0 = 1'b1; src0 = 3'd1; dst0 = 3'd2;
    req1 = 1'b1; src1 = 3'd4; dst1 = 3'd7;
    do_xfer(0, 8'h02, 8'h04, 0, 8'd1);
    do_xfer(1, 8'h10, 8'h80, 0, 8'd2);
    do_xfer(0, 8'h02, 8'h04, 0, 8'd3);
    do_xfer(1, 8'h10, 8'h80, 0, 8'd4);
    req0 = 1'b0;
    src1 = 3'd2; dst1 = 3'd0;
    do_xfer(1, 8'h00, 8'h00, 1, 8'd4);
    src1 = 3'd4; dst1 = 3'd4;
    do_xfer(1, 8'h00, 8'h00, 1, 8'd4);
    req1 = 1'b0;
    req0 = 1'b1; src0 = 3'd3; dst0 = 3'd5;
    tick();
    tick();
    chk("rw_ie", in_en, 8'h20);
    clr = 1'b0;
    tick();
    clr = 1'b1;
    req0 = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_oe", out_en, 0);
    chk("rw_ie0", in_en, 0);
    chk("rw_ack", ack0, 0);
    chk("rw_cnt", xfer_cnt, 0);
    tick();
    chk("rw_ack_after", ack0, 0);
    chk("rw_ie_after", in_en, 0);
    req0 = 1'b1; src0 = 3'd1; dst0 = 3'd2;
    for (int i = 0; i < 255; i++) repeat (4) tick();
    chk("wrap_255", xfer_cnt, 8'd255);
    do_xfer(0, 8'h02, 8'h04, 0, 8'd0);
    req0 = 1'b0;
    tick();
    chk("wrap_0", xfer_cnt, 8'd0);
    mon = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
